// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_controller
// Description : Button-driven stopwatch FSM with a tick prescaler, a
//               counter-chain clear, lap capture and a 4-digit display scan.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_controller #(
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lr,
    input  logic [15:0] digits,
    output logic        cnt_en,
    output logic        cnt_clr_n,
    output logic [3:0]  seg_sel,
    output logic [3:0]  seg_dat,
    output logic [1:0]  state
);

    localparam int c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_LAP   = 2'b11;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_SCAN_W-1:0]  r_scan;
    logic [1:0]           r_idx;
    logic [15:0]          r_lap;
    logic                 r_ss_prev;
    logic                 r_lr_prev;
    logic                 r_armed;
    logic                 r_clr_n;
    logic                 w_ss_press;
    logic                 w_lr_press;
    logic                 w_clear;
    logic                 w_capture;
    logic                 w_running;
    logic [15:0]          w_src;

    // A button already high when reset releases is absorbed on the first edge.
    assign w_ss_press = r_armed & btn_ss & ~r_ss_prev;
    assign w_lr_press = r_armed & btn_lr & ~r_lr_prev;
    assign cnt_clr_n  = r_clr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_capture   = 1'b0;
        if (w_ss_press) begin
            case (r_state)
                c_IDLE:  w_state_nxt = c_RUN;
                c_RUN:   w_state_nxt = c_PAUSE;
                c_PAUSE: w_state_nxt = c_RUN;
                c_LAP:   w_state_nxt = c_PAUSE;
                default: w_state_nxt = c_IDLE;
            endcase
        end else if (w_lr_press) begin
            case (r_state)
                c_IDLE:  w_clear = 1'b1;
                c_RUN: begin
                    w_state_nxt = c_LAP;
                    w_capture   = 1'b1;
                end
                c_PAUSE: begin
                    w_state_nxt = c_IDLE;
                    w_clear     = 1'b1;
                end
                c_LAP:   w_state_nxt = c_RUN;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        state     = r_state;
        w_running = (r_state == c_RUN) || (r_state == c_LAP);
        cnt_en    = w_running && (r_presc == c_TICK_LAST);
        w_src     = (r_state == c_LAP) ? r_lap : digits;
        seg_sel   = ~(4'b0001 << r_idx);
        seg_dat   = w_src[{r_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_scan    <= '0;
            r_idx     <= 2'd0;
            r_lap     <= 16'h0000;
            r_ss_prev <= 1'b0;
            r_lr_prev <= 1'b0;
            r_armed   <= 1'b0;
            r_clr_n   <= 1'b0;
        end else begin
            r_ss_prev <= btn_ss;
            r_lr_prev <= btn_lr;
            r_armed   <= 1'b1;
            r_clr_n   <= ~w_clear;

            // Prescaler freezes outside RUN/LAP so a resume continues the period.
            if (w_clear) begin
                r_presc <= '0;
            end else if (w_running) begin
                r_presc <= cnt_en ? '0 : r_presc + 1'b1;
            end

            if (w_capture) begin
                r_lap <= digits;
            end

            if (r_scan == c_SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
